// File: rtl/arcade_input_pkg.sv
// Shared constants for arcade_input: joystick bit layout and the keyboard scancode table.
package arcade_input_pkg;

  typedef logic [8:0] scan_entry_t;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_BTN0  = 4;
  // Trailing controls sit at BUTTONS + offset in the joystick word.
  localparam int JOY_START_OFS   = 4;
  localparam int JOY_COIN_OFS    = 5;
  localparam int JOY_PAUSE_OFS   = 6;
  localparam int JOY_SERVICE_OFS = 7;

  localparam int CTL_RIGHT   = 0;
  localparam int CTL_LEFT    = 1;
  localparam int CTL_DOWN    = 2;
  localparam int CTL_UP      = 3;
  localparam int CTL_BTN0    = 4;
  localparam int CTL_START   = 7;
  localparam int CTL_COIN    = 8;
  localparam int CTL_PAUSE   = 9;
  localparam int CTL_SERVICE = 10;
  localparam int NUM_CTL     = 11;

  localparam int KEY_PLAYERS = 2;
  localparam int KEY_BUTTONS = 3;

  // Entry = {valid, scancode}; an all-zero entry means the control has no key.
  localparam scan_entry_t SCAN_TABLE [KEY_PLAYERS][NUM_CTL] = '{
    '{9'h174, 9'h16B, 9'h172, 9'h175, 9'h114, 9'h111, 9'h129, 9'h116, 9'h12E, 9'h14D, 9'h146},
    '{9'h134, 9'h123, 9'h12B, 9'h12D, 9'h11C, 9'h11B, 9'h115, 9'h11E, 9'h136, 9'h000, 9'h145}
  };

endpackage

// File: rtl/arcade_input_coin_stretch.sv
// coin_stretch: widens a coin request to at least COIN_CYCLES cycles, then follows the raw input.
module coin_stretch #(
  parameter int COIN_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_coin
);

  localparam int CW = $clog2(COIN_CYCLES);

  logic          r_coin;
  logic [CW-1:0] r_cnt;

  // Rise only from a low output; hold for the minimum width, then track the raw level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coin <= 1'b0;
      r_cnt  <= '0;
    end else if (!r_coin) begin
      r_coin <= i_raw;
      r_cnt  <= CW'(COIN_CYCLES - 1);
    end else if (r_cnt != '0) begin
      r_cnt  <= r_cnt - CW'(1);
    end else begin
      r_coin <= i_raw;
    end
  end

  assign o_coin = r_coin;

endmodule

// File: rtl/arcade_input.sv
// arcade_input: merges PS/2 key states and HPS joystick words into per-player arcade controls.
// Define ARCADE_INPUT_AUTOFIRE_EN to gate masked buttons with a free-running autofire phase.
module arcade_input
  import arcade_input_pkg::*;
#(
  parameter int PLAYERS      = 2,
  parameter int BUTTONS      = 3,
  parameter int COIN_CYCLES  = 16,
  parameter int AUTOFIRE_DIV = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [10:0]                     ps2_key,
  input  logic [PLAYERS-1:0][31:0]        joystick,
  input  logic [BUTTONS-1:0]              autofire_mask,
  input  logic                            pause_clear,
  output logic [PLAYERS-1:0]              up,
  output logic [PLAYERS-1:0]              down,
  output logic [PLAYERS-1:0]              left,
  output logic [PLAYERS-1:0]              right,
  output logic [PLAYERS-1:0][BUTTONS-1:0] buttons,
  output logic [PLAYERS-1:0]              start,
  output logic [PLAYERS-1:0]              coin,
  output logic [PLAYERS-1:0]              service,
  output logic                            paused
);

  localparam int NKP = (PLAYERS < KEY_PLAYERS) ? PLAYERS : KEY_PLAYERS;

  logic                            r_toggle;
  logic                            r_armed;
  logic [NKP-1:0][NUM_CTL-1:0]     r_key;
  logic                            r_pause_prev;
  logic                            w_event;
  logic                            w_pause_any;
  logic                            w_unused;
  logic [PLAYERS-1:0][NUM_CTL-1:0] w_key;
  logic [PLAYERS-1:0]              w_up, w_down, w_left, w_right;
  logic [PLAYERS-1:0]              w_start, w_coin, w_pause, w_service;
  logic [PLAYERS-1:0][BUTTONS-1:0] w_btn;
  logic [PLAYERS-1:0][BUTTONS-1:0] w_btn_out;

  // r_armed stays low for the first cycle after reset so a held toggle bit is not seen as an event.
  assign w_event  = r_armed & (ps2_key[10] ^ r_toggle);
  assign w_unused = ^{joystick, ps2_key[8], autofire_mask, r_key};

  // Key state capture from PS/2 events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_toggle <= 1'b0;
      r_armed  <= 1'b0;
      r_key    <= '0;
    end else begin
      r_toggle <= ps2_key[10];
      r_armed  <= 1'b1;
      for (int p = 0; p < NKP; p++) begin
        for (int c = 0; c < NUM_CTL; c++) begin
          if (w_event && (SCAN_TABLE[p][c] == {1'b1, ps2_key[7:0]})) begin
            r_key[p][c] <= ps2_key[9];
          end
        end
      end
    end
  end

  for (genvar gp = 0; gp < PLAYERS; gp++) begin : g_key
    if (gp < NKP) begin : g_kbd
      assign w_key[gp] = r_key[gp];
    end else begin : g_joy_only
      assign w_key[gp] = '0;
    end
  end

  // Raw controls: key state OR joystick bit.
  always_comb begin
    w_up = '0; w_down = '0; w_left = '0; w_right = '0;
    w_start = '0; w_coin = '0; w_pause = '0; w_service = '0;
    w_btn = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      w_right[p]   = joystick[p][JOY_RIGHT] | w_key[p][CTL_RIGHT];
      w_left[p]    = joystick[p][JOY_LEFT]  | w_key[p][CTL_LEFT];
      w_down[p]    = joystick[p][JOY_DOWN]  | w_key[p][CTL_DOWN];
      w_up[p]      = joystick[p][JOY_UP]    | w_key[p][CTL_UP];
      w_start[p]   = joystick[p][BUTTONS + JOY_START_OFS]   | w_key[p][CTL_START];
      w_coin[p]    = joystick[p][BUTTONS + JOY_COIN_OFS]    | w_key[p][CTL_COIN];
      w_pause[p]   = joystick[p][BUTTONS + JOY_PAUSE_OFS]   | w_key[p][CTL_PAUSE];
      w_service[p] = joystick[p][BUTTONS + JOY_SERVICE_OFS] | w_key[p][CTL_SERVICE];
      for (int i = 0; i < BUTTONS; i++) begin
        if (i < KEY_BUTTONS) begin
          w_btn[p][i] = joystick[p][JOY_BTN0 + i] | w_key[p][CTL_BTN0 + i];
        end else begin
          w_btn[p][i] = joystick[p][JOY_BTN0 + i];
        end
      end
    end
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int AFW = $clog2(AUTOFIRE_DIV);

  logic [AFW-1:0] r_af_cnt;
  logic           r_af_phase;

  // Free-running autofire divider; the phase flips once every AUTOFIRE_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_af_cnt   <= '0;
      r_af_phase <= 1'b0;
    end else if (r_af_cnt == AFW'(AUTOFIRE_DIV - 1)) begin
      r_af_cnt   <= '0;
      r_af_phase <= ~r_af_phase;
    end else begin
      r_af_cnt   <= r_af_cnt + AFW'(1);
    end
  end

  // Masked buttons are gated by the autofire phase.
  always_comb begin
    w_btn_out = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      for (int i = 0; i < BUTTONS; i++) begin
        if (autofire_mask[i]) begin
          w_btn_out[p][i] = w_btn[p][i] & r_af_phase;
        end else begin
          w_btn_out[p][i] = w_btn[p][i];
        end
      end
    end
  end
`else
  assign w_btn_out = w_btn;
`endif

  // Registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up <= '0; down <= '0; left <= '0; right <= '0;
      start <= '0; service <= '0; buttons <= '0;
    end else begin
      up      <= w_up;
      down    <= w_down;
      left    <= w_left;
      right   <= w_right;
      start   <= w_start;
      service <= w_service;
      buttons <= w_btn_out;
    end
  end

  for (genvar gc = 0; gc < PLAYERS; gc++) begin : g_coin
    coin_stretch #(
      .COIN_CYCLES(COIN_CYCLES)
    ) u_coin (
      .clk   (clk),
      .rst_n (rst_n),
      .i_raw (w_coin[gc]),
      .o_coin(coin[gc])
    );
  end

  assign w_pause_any = |w_pause;

  // Pause latch toggles on a rising edge of any player's pause; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pause_prev <= 1'b0;
      paused       <= 1'b0;
    end else begin
      r_pause_prev <= w_pause_any;
      if (pause_clear) begin
        paused <= 1'b0;
      end else if (w_pause_any && !r_pause_prev) begin
        paused <= ~paused;
      end
    end
  end

endmodule

// File: tb/tb_arcade_input.sv
// Randomised self-checking bench for arcade_input against a behavioural control model.
module tb_arcade_input;

  localparam int P  = 4;
  localparam int B  = 6;
  localparam int CC = 16;
  localparam int AD = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [10:0]         ps2_key;
  logic [P-1:0][31:0]  joystick;
  logic [B-1:0]        autofire_mask;
  logic                pause_clear;
  logic [P-1:0]        up, down, left, right, start, coin, service;
  logic [P-1:0][B-1:0] buttons;
  logic                paused;

  always #5 clk = ~clk;

  arcade_input #(
    .PLAYERS(P), .BUTTONS(B), .COIN_CYCLES(CC), .AUTOFIRE_DIV(AD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2_key(ps2_key), .joystick(joystick),
    .autofire_mask(autofire_mask), .pause_clear(pause_clear),
    .up(up), .down(down), .left(left), .right(right), .buttons(buttons),
    .start(start), .coin(coin), .service(service), .paused(paused)
  );

  int tests = 0;
  int fails = 0;

  // Control order: right, left, down, up, b0, b1, b2, start, coin, pause, service.
  logic [7:0] p1_codes [11] = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h14, 8'h11, 8'h29, 8'h16, 8'h2E, 8'h4D, 8'h46};
  logic [7:0] p2_codes [11] = '{8'h34, 8'h23, 8'h2B, 8'h2D, 8'h1C, 8'h1B, 8'h15, 8'h1E, 8'h36, 8'h00, 8'h45};

  bit                  keys [256];
  bit                  m_prev_tog, m_armed, m_pause_prev;
  int                  coin_len [P];
  int                  af_edges;
  logic [P-1:0]        e_up, e_down, e_left, e_right, e_start, e_coin, e_service;
  logic [P-1:0][B-1:0] e_btn;
  logic                e_paused;

  function automatic bit key_on(int p, int ctl);
    if (ctl < 0) return 1'b0;
    else if (p == 0) return keys[p1_codes[ctl]];
    else if (p == 1 && ctl != 9) return keys[p2_codes[ctl]];
    else return 1'b0;
  endfunction

  function automatic bit rc(int p, int jbit, int ctl);
    return joystick[p][jbit] | key_on(p, ctl);
  endfunction

  task automatic model_edge();
    bit any_pause;
    bit craw;
    bit braw;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    bit ph;
`endif
    if (!rst_n) begin
      foreach (keys[k]) keys[k] = 1'b0;
      foreach (coin_len[k]) coin_len[k] = 0;
      m_prev_tog = 1'b0; m_armed = 1'b0; m_pause_prev = 1'b0; af_edges = 0;
      e_up = '0; e_down = '0; e_left = '0; e_right = '0; e_start = '0;
      e_coin = '0; e_service = '0; e_btn = '0; e_paused = 1'b0;
      return;
    end
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    ph = ((af_edges / AD) % 2) == 1;
`endif
    af_edges++;
    any_pause = 1'b0;
    for (int p = 0; p < P; p++) begin
      e_right[p]   = rc(p, 0, 0);
      e_left[p]    = rc(p, 1, 1);
      e_down[p]    = rc(p, 2, 2);
      e_up[p]      = rc(p, 3, 3);
      e_start[p]   = rc(p, B + 4, 7);
      e_service[p] = rc(p, B + 7, 10);
      any_pause    = any_pause | rc(p, B + 6, 9);
      for (int i = 0; i < B; i++) begin
        braw = rc(p, 4 + i, (i < 3) ? 4 + i : -1);
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        e_btn[p][i] = autofire_mask[i] ? (braw & ph) : braw;
`else
        e_btn[p][i] = braw;
`endif
      end
      craw = rc(p, B + 5, 8);
      if (e_coin[p] && coin_len[p] < CC) coin_len[p]++;
      else if (e_coin[p]) e_coin[p] = craw;
      else if (craw) begin
        e_coin[p] = 1'b1;
        coin_len[p] = 1;
      end
    end
    if (pause_clear) e_paused = 1'b0;
    else if (any_pause && !m_pause_prev) e_paused = !e_paused;
    m_pause_prev = any_pause;
    if (m_armed && (ps2_key[10] != m_prev_tog)) keys[ps2_key[7:0]] = ps2_key[9];
    m_prev_tog = ps2_key[10];
    m_armed    = 1'b1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("up",      32'(up),      32'(e_up));
    chk("down",    32'(down),    32'(e_down));
    chk("left",    32'(left),    32'(e_left));
    chk("right",   32'(right),   32'(e_right));
    chk("buttons", 32'(buttons), 32'(e_btn));
    chk("start",   32'(start),   32'(e_start));
    chk("coin",    32'(coin),    32'(e_coin));
    chk("service", 32'(service), 32'(e_service));
    chk("paused",  32'(paused),  32'(e_paused));
  endtask

  task automatic key_evt(logic [7:0] code, logic pr, logic ext);
    ps2_key = {~ps2_key[10], pr, ext, code};
  endtask

  initial begin
    int n, h0, h1;
    logic [7:0] code;
    int idx;

    rst_n = 1'b0;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    joystick = '0;
    autofire_mask = '0;
    pause_clear = 1'b0;
    repeat (3) step();
    chk("reset_all_zero", 32'({up, down, left, right, start, coin, service, paused}), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("no_phantom_event", 32'({up, buttons}), 32'd0);

    // Keyboard up for player 1: two-cycle latency on press and release.
    key_evt(8'h75, 1'b1, 1'b0);
    step(); chk("up0_press_t1", 32'(up[0]), 32'd0);
    step(); chk("up0_press_t2", 32'(up[0]), 32'd1);
    key_evt(8'h75, 1'b0, 1'b0);
    step(); chk("up0_rel_t1", 32'(up[0]), 32'd1);
    step(); chk("up0_rel_t2", 32'(up[0]), 32'd0);

    // Coin stretch: single-cycle pulse and long hold.
    joystick[1][B + 5] = 1'b1;
    step(); n = int'(coin[1]);
    joystick[1][B + 5] = 1'b0;
    repeat (30) begin step(); n += int'(coin[1]); end
    chk("coin_pulse_width", 32'(n), 32'd16);
    joystick[1][B + 5] = 1'b1;
    n = 0;
    repeat (40) begin step(); n += int'(coin[1]); end
    joystick[1][B + 5] = 1'b0;
    repeat (30) begin step(); n += int'(coin[1]); end
    chk("coin_hold_width", 32'(n), 32'd40);

    // Reset in the middle of a coin pulse.
    joystick[0][B + 5] = 1'b1;
    step();
    joystick[0][B + 5] = 1'b0;
    step(); chk("coin_mid_pulse", 32'(coin[0]), 32'd1);
    rst_n = 1'b0;
    #1 chk("coin_async_drop", 32'(coin[0]), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // Pause key pressed/released twice, then rise together with clear.
    key_evt(8'h4D, 1'b1, 1'b0); repeat (2) step();
    chk("pause_first", 32'(paused), 32'd1);
    key_evt(8'h4D, 1'b0, 1'b0); repeat (2) step();
    key_evt(8'h4D, 1'b1, 1'b0); repeat (2) step();
    chk("pause_second", 32'(paused), 32'd0);
    key_evt(8'h4D, 1'b0, 1'b0); repeat (2) step();
    joystick[0][B + 6] = 1'b1;
    pause_clear = 1'b1;
    step(); chk("pause_clear_priority", 32'(paused), 32'd0);
    pause_clear = 1'b0;
    step(); chk("pause_no_late_toggle", 32'(paused), 32'd0);
    joystick[0][B + 6] = 1'b0;
    step();

    // Player 4 joystick-only controls, and a player-1 key leaves player 4 alone.
    joystick[3] = 32'h0000_26D0;
    step();
    chk("p4_buttons", 32'(buttons[3]), 32'h2D);
    chk("p4_start_service", 32'({start[3], coin[3], service[3]}), 32'b101);
    joystick[3] = 32'h0000_1000;
    step(); chk("p4_pause", 32'(paused), 32'd1);
    joystick[3] = '0;
    pause_clear = 1'b1; step(); pause_clear = 1'b0;
    key_evt(8'h75, 1'b1, 1'b1); repeat (2) step();
    chk("p4_key_isolated", 32'({up[3], up[0]}), 32'b01);
    key_evt(8'h75, 1'b0, 1'b0); repeat (2) step();

    // Autofire on button 0 only.
    autofire_mask = 6'b000001;
    joystick[0][4] = 1'b1;
    joystick[0][5] = 1'b1;
    repeat (3) step();
    h0 = 0; h1 = 0;
    repeat (16) begin step(); h0 += int'(buttons[0][0]); h1 += int'(buttons[0][1]); end
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    chk("autofire_btn0_duty", 32'(h0), 32'd8);
`else
    chk("autofire_btn0_steady", 32'(h0), 32'd16);
`endif
    chk("autofire_btn1_steady", 32'(h1), 32'd16);
    joystick = '0;
    autofire_mask = '0;
    step();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, 27);
        if (idx < 11) code = p1_codes[idx];
        else if (idx < 22) code = p2_codes[idx - 11];
        else code = 8'($urandom);
        key_evt(code, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 7) == 0) begin
        ps2_key[7:0] = 8'($urandom);
      end
      if ($urandom_range(0, 3) == 0)
        joystick[$urandom_range(0, P - 1)] = $urandom & $urandom & $urandom & 32'h0000_3FFF;
      if ($urandom_range(0, 63) == 0) autofire_mask = 6'($urandom);
      pause_clear = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arcade_input.md
ARCADE_INPUT -- requirements
Module: arcade_input

Interface
REQ-001 SHALL have parameter PLAYERS, default 2, number of player channels (1..4).
REQ-002 SHALL have parameter BUTTONS, default 3, fire buttons per player (1..6).
REQ-003 SHALL have parameter COIN_CYCLES, default 16, minimum coin output pulse width in clk cycles (>=2).
REQ-004 SHALL have parameter AUTOFIRE_DIV, default 1024, autofire half-period in clk cycles (>=2).
REQ-005 SHALL have ports:
  clk  in  1  system clock.
  rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
  ps2_key  in  11  [10] toggle-per-event, [9] pressed, [8] extended (ignored), [7:0] scancode.
  joystick  in  PLAYERS x 32  per-player HPS joystick word.
  autofire_mask  in  BUTTONS  per-button autofire enable, shared by all players.
  pause_clear  in  1  synchronous clear of paused latch.
  up, down, left, right  out  PLAYERS  direction per player.
  buttons  out  PLAYERS x BUTTONS  fire buttons.
  start, coin, service  out  PLAYERS  per-player controls.
  paused  out  1  pause latch.

Function
REQ-006 SHALL map joystick bits: 0 right, 1 left, 2 down, 3 up, 4+i button i, 4+BUTTONS start, 5+BUTTONS coin, 6+BUTTONS pause, 7+BUTTONS service.
REQ-007 SHALL detect a keyboard event when ps2_key[10] differs from its registered copy; on event, key state for matching scancode SHALL become ps2_key[9].
REQ-008 SHALL decode player 1 keys: 75 up, 72 down, 6B left, 74 right, 14/11/29 buttons 0/1/2, 16 start, 2E coin, 4D pause, 46 service; player 2: 2D up, 2B down, 23 left, 34 right, 1C/1B/15 buttons 0/1/2, 1E start, 36 coin, 45 service (hex); players 3..4 and buttons >=3 SHALL be joystick-only.
REQ-009 Each raw control SHALL be key state OR joystick bit; all outputs SHALL be registered.
REQ-010 Latency SHALL be 1 cycle joystick-to-output, 2 cycles ps2 event-to-output.
REQ-011 Coin output SHALL rise 1 cycle after raw coin rises, stay high at least COIN_CYCLES cycles, and thereafter follow raw coin; a new rise SHALL retrigger only after the output has fallen.
REQ-012 paused SHALL toggle on each rising edge of OR of all players' raw pause; pause_clear SHALL force 0 and take priority over a simultaneous toggle.
REQ-013 Unmatched scancodes SHALL change no state; simultaneous key and joystick for one control SHALL yield 1.

Reset
REQ-014 While rst_n low all outputs, key states, coin counters, autofire state and paused SHALL be 0.
REQ-015 First cycle after reset release SHALL only capture ps2_key[10] (no event decoded), preventing a phantom event.
REQ-016 Reset asserted mid-coin-pulse SHALL drop coin immediately.

Configuration
REQ-017 With ARCADE_INPUT_AUTOFIRE_EN defined: free-running counter toggles phase every AUTOFIRE_DIV cycles; button i output = raw AND phase when autofire_mask[i]=1, raw otherwise; phase reset 0, counter not reset by mask changes.
REQ-018 Without ARCADE_INPUT_AUTOFIRE_EN: autofire_mask ignored, buttons = raw, no counter logic synthesised.

Structure
REQ-019 Shared package arcade_input_pkg SHALL hold joystick bit-index constants and the scancode table (per player, per control).
REQ-020 Coin stretch SHALL be a sub-module coin_stretch instantiated once per player.

Verification
REQ-021 Reset release with ps2_key[10]=1 held -> no key state changes, all outputs 0.
REQ-022 ps2_key = {toggle flip,1,0,8'h75} at cycle t -> up[0]=1 at t+2; flip with pressed=0 -> up[0]=0 two cycles later.
REQ-023 joystick[1][8] pulsed 1 cycle, COIN_CYCLES=16 -> coin[1] high exactly 16 cycles; held 40 cycles -> coin[1] high 40 cycles.
REQ-024 Pause key 4D pressed/released twice -> paused 0->1->0; pause rise coincident with pause_clear -> paused 0.
REQ-025 With macro, AUTOFIRE_DIV=4, mask=3'b001, button 0 held -> buttons[0][0] square wave 4 high/4 low, button 1 held -> steady 1; without macro -> both steady 1.
REQ-026 PLAYERS=4, BUTTONS=6 -> joystick[3] bits 4..13 drive buttons[3][5:0], start, coin, pause, service; scancode 75 does not affect player 3.
